// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg -- shared types and helpers for the DDS frequency-sweep controller.
//
// Contents:
//   state_e       sweep FSM state encoding
//   M_DEF, D_DEF, PIPE_LAT_DEF   default widths and DDS pipeline latency
//   up_step_ok    true when cur+step stays <= limit (no wrap, no overshoot)
//   down_step_ok  true when cur-step stays >= floor (no underflow)
//
// Configuration macro: DDS_SWEEP_BIDIR_EN adds the RUN_DOWN state and the
// down-step helper; without it the sweep is up-only.
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int M_DEF        = 27;
  localparam int D_DEF        = 16;
  localparam int PIPE_LAT_DEF = 4;

  // Frequency arithmetic is done on zero-extended operands of this width
  // plus one carry bit, so tuning words up to 64 bits are supported.
  localparam int CALC_W = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    RUN_UP   = 3'd2,
`ifdef DDS_SWEEP_BIDIR_EN
    RUN_DOWN = 3'd5,
`endif
    FLUSH    = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Next frequency is formed one bit wider than the operands, so a sum that
  // would overflow the tuning word always compares greater than the limit.
  function automatic logic up_step_ok(input logic [CALC_W-1:0] cur,
                                      input logic [CALC_W-1:0] step,
                                      input logic [CALC_W-1:0] lim);
    logic [CALC_W:0] nxt;
    nxt = {1'b0, cur} + {1'b0, step};
    return nxt <= {1'b0, lim};
  endfunction

`ifdef DDS_SWEEP_BIDIR_EN
  // cur-step >= floor rewritten as cur >= floor+step avoids any underflow.
  function automatic logic down_step_ok(input logic [CALC_W-1:0] cur,
                                        input logic [CALC_W-1:0] step,
                                        input logic [CALC_W-1:0] floor_v);
    logic [CALC_W:0] lim;
    lim = {1'b0, floor_v} + {1'b0, step};
    return {1'b0, cur} >= lim;
  endfunction
`endif

endpackage

// File: rtl/dds_dwell_timer.sv
// -----------------------------------------------------------------------------
// dds_dwell_timer -- counts the cycles spent on each sweep frequency.
//
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (counter cleared)
//   load    in   load period into the counter
//   en      in   count down while the sweep is running
//   period  in   D  cycles per step (caller guarantees >= 1)
//   expire  out  high during the last cycle of each dwell period; the counter
//                reloads itself on that cycle so consecutive steps abut.
// -----------------------------------------------------------------------------
module dds_dwell_timer #(
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [D-1:0] period,
  output logic         expire
);

  logic [D-1:0] cnt;

  assign expire = en && (cnt <= D'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period;
    end else if (en) begin
      if (expire) cnt <= period;
      else        cnt <= cnt - D'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl -- steps a DDS tuning word from f_start to f_stop in f_step
// increments, holding each word for dwell cycles, then flushes the DDS
// pipeline and reports done.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 sweep request (sampled in IDLE)
//   abort                 stop a running sweep (CLEAR / RUN_*)
//   f_start/f_stop/f_step M  sweep bounds and increment, unsigned
//   dwell                 D  cycles per step (0 behaves as 1)
//   P                     M  tuning word to the DDS
//   ena_ac/rst_ac/val_in  DDS accumulator enable, clear, input valid
//   val_out               DDS output valid (monitor only)
//   busy, done, cfg_err   status; step_idx  M  current step number
//
// All outputs are registered decodes of the current state, so they trail the
// state register by one cycle: start at edge k gives rst_ac at k+1 and the
// first tuning word at k+2. cfg_err is the exception: it is registered
// straight from the rejected request.
//
// Configuration macro: DDS_SWEEP_BIDIR_EN -- after reaching the top the sweep
// walks back down to f_start before flushing.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int D        = D_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] f_start,
  input  logic [M-1:0] f_stop,
  input  logic [M-1:0] f_step,
  input  logic [D-1:0] dwell,
  output logic [M-1:0] P,
  output logic         ena_ac,
  output logic         rst_ac,
  output logic         val_in,
  input  logic         val_out,
  output logic         busy,
  output logic         done,
  output logic         cfg_err,
  output logic [M-1:0] step_idx
);

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e state, state_nxt;

  // Sweep configuration captured at start; later input changes are ignored.
  logic [M-1:0] lat_stop, lat_step;
  logic [D-1:0] lat_dwell;
`ifdef DDS_SWEEP_BIDIR_EN
  logic [M-1:0] lat_start;
`endif

  logic [M-1:0]  freq;       // tuning word of the current step
  logic [M-1:0]  step_cnt;   // steps taken since CLEAR
  logic [FW-1:0] flush_cnt;

  logic cfg_ok, up_ok, dn_ok, expire, flush_last;
  logic accept, adv_up, adv_dn;
  logic p_upd, idx_upd;
  logic ena_nxt, rst_nxt, val_nxt, busy_nxt, done_nxt, cfg_err_nxt;
  logic [D-1:0] dwell_eff;

  // The DDS valid is observed for debug only; sequencing is purely cycle
  // counted, so the input is deliberately left unconnected to logic.
  logic unused_val_out;
  assign unused_val_out = val_out;

  assign cfg_ok     = (f_step != '0) && (f_start <= f_stop);
  assign up_ok      = up_step_ok(CALC_W'(freq), CALC_W'(lat_step), CALC_W'(lat_stop));
`ifdef DDS_SWEEP_BIDIR_EN
  assign dn_ok      = down_step_ok(CALC_W'(freq), CALC_W'(lat_step), CALC_W'(lat_start));
`else
  assign dn_ok      = 1'b0;
`endif
  assign dwell_eff  = (lat_dwell == '0) ? D'(1) : lat_dwell;
  assign flush_last = (flush_cnt == FW'(PIPE_LAT - 1));

  dds_dwell_timer #(.D(D)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == CLEAR),
`ifdef DDS_SWEEP_BIDIR_EN
    .en     ((state == RUN_UP) || (state == RUN_DOWN)),
`else
    .en     (state == RUN_UP),
`endif
    .period (dwell_eff),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    adv_up      = 1'b0;
    adv_dn      = 1'b0;
    p_upd       = 1'b0;
    idx_upd     = 1'b0;
    ena_nxt     = 1'b0;
    rst_nxt     = 1'b0;
    val_nxt     = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    cfg_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            state_nxt = CLEAR;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      CLEAR: begin
        rst_nxt   = 1'b1;
        busy_nxt  = 1'b1;
        idx_upd   = 1'b1;
        state_nxt = abort ? FLUSH : RUN_UP;
      end
      RUN_UP: begin
        ena_nxt  = 1'b1;
        val_nxt  = 1'b1;
        busy_nxt = 1'b1;
        p_upd    = 1'b1;
        idx_upd  = 1'b1;
        if (abort) begin
          state_nxt = FLUSH;
        end else if (expire) begin
          if (up_ok) begin
            adv_up = 1'b1;
          end else begin
`ifdef DDS_SWEEP_BIDIR_EN
            // Turn around immediately so the top word is held only one dwell.
            adv_dn    = dn_ok;
            state_nxt = dn_ok ? RUN_DOWN : FLUSH;
`else
            state_nxt = FLUSH;
`endif
          end
        end
      end
`ifdef DDS_SWEEP_BIDIR_EN
      RUN_DOWN: begin
        ena_nxt  = 1'b1;
        val_nxt  = 1'b1;
        busy_nxt = 1'b1;
        p_upd    = 1'b1;
        idx_upd  = 1'b1;
        if (abort) begin
          state_nxt = FLUSH;
        end else if (expire) begin
          if (dn_ok) adv_dn    = 1'b1;
          else       state_nxt = FLUSH;
        end
      end
`endif
      FLUSH: begin
        ena_nxt  = 1'b1;
        busy_nxt = 1'b1;
        if (flush_last) state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_stop  <= '0;
      lat_step  <= '0;
      lat_dwell <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
      lat_start <= '0;
`endif
      freq      <= '0;
      step_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept) begin
        lat_stop  <= f_stop;
        lat_step  <= f_step;
        lat_dwell <= dwell;
`ifdef DDS_SWEEP_BIDIR_EN
        lat_start <= f_start;
`endif
        freq      <= f_start;
        step_cnt  <= '0;
      end else if (adv_up) begin
        freq     <= freq + lat_step;
        step_cnt <= step_cnt + M'(1);
      end else if (adv_dn) begin
        freq     <= freq - lat_step;
        step_cnt <= step_cnt + M'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
    end
  end

  // rst_ac is asserted during reset so the DDS accumulator clears together
  // with the controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      P        <= '0;
      step_idx <= '0;
      ena_ac   <= 1'b0;
      rst_ac   <= 1'b1;
      val_in   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (p_upd)   P        <= freq;
      if (idx_upd) step_idx <= step_cnt;
      ena_ac  <= ena_nxt;
      rst_ac  <= rst_nxt;
      val_in  <= val_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cfg_err <= cfg_err_nxt;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl -- self-checking bench for dds_sweep_ctrl.
// The reference model builds the list of tuning words a sweep must visit and
// derives the expected output pattern for every cycle after start from the
// cycle index alone. Honours DDS_SWEEP_BIDIR_EN when compiled with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  localparam int M  = 27;
  localparam int D  = 16;
  localparam int PL = 4;
  localparam logic [M-1:0] TOP = '1;   // 2^27-1

  logic         clk = 1'b0;
  logic         rst_n, start, abort, val_out;
  logic [M-1:0] f_start, f_stop, f_step;
  logic [D-1:0] dwell;
  logic [M-1:0] P, step_idx;
  logic         ena_ac, rst_ac, val_in, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  // Last tuning word / step number the DUT should be showing while idle.
  logic [M-1:0] held_p, held_idx;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.M(M), .D(D), .PIPE_LAT(PL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .P        (P),
    .ena_ac   (ena_ac),
    .rst_ac   (rst_ac),
    .val_in   (val_in),
    .val_out  (val_out),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .step_idx (step_idx)
  );

  function automatic logic [63:0] obs_vec();
    return {4'b0, P, step_idx, ena_ac, val_in, rst_ac, busy, done, cfg_err};
  endfunction

  function automatic logic [63:0] exp_vec(input logic [M-1:0] p, input logic [M-1:0] idx,
                                          input logic ena, input logic val, input logic rst,
                                          input logic bsy, input logic dn, input logic cerr);
    return {4'b0, p, idx, ena, val, rst, bsy, dn, cerr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one sweep. a = edge index (after start edge) at which abort is
  // sampled; 0 or beyond the run phase means no abort.
  task automatic run_sweep(input string tag, input logic [M-1:0] fs, input logic [M-1:0] fe,
                           input logic [M-1:0] st, input logic [D-1:0] dw, input int a);
    longint unsigned fl[$];
    longint unsigned f, fsl, fel, stl;
    int dwe, len, lp, idx;
    logic e_ena, e_val, e_rst, e_busy, e_done;
    fsl = longint'(fs);
    fel = longint'(fe);
    stl = longint'(st);
    f   = fsl;
    fl.push_back(f);
    while (f + stl <= fel) begin
      f += stl;
      fl.push_back(f);
    end
`ifdef DDS_SWEEP_BIDIR_EN
    while (f >= fsl + stl) begin
      f -= stl;
      fl.push_back(f);
    end
`endif
    dwe = (dw == 0) ? 1 : int'(dw);
    len = fl.size() * dwe;
    lp  = (a >= 1 && a <= len) ? a - 1 : len;

    f_start = fs; f_stop = fe; f_step = st; dwell = dw;
    abort = 1'b0;
    start = 1'b1;
    tick();                       // edge k: request accepted
    start   = 1'b0;
    f_start = M'($urandom);       // must not affect the running sweep
    f_stop  = M'($urandom);
    f_step  = M'($urandom);
    dwell   = D'($urandom);

    for (int j = 1; j <= lp + PL + 3; j++) begin
      abort = ((j == a) && (a <= len)) ||
              ((j >= lp + 2) && (j <= lp + PL + 1) && ($urandom_range(0, 3) == 0));
      start   = (j <= lp + PL + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      val_out = 1'($urandom_range(0, 1));
      tick();
      e_ena = 0; e_val = 0; e_rst = 0; e_busy = 0; e_done = 0;
      if (j == 1) begin
        e_rst = 1; e_busy = 1; held_idx = '0;
      end else if (j <= lp + 1) begin
        idx = (j - 2) / dwe;
        held_p = M'(fl[idx]);
        held_idx = M'(idx);
        e_ena = 1; e_val = 1; e_busy = 1;
      end else if (j <= lp + PL + 1) begin
        e_ena = 1; e_busy = 1;
      end else if (j == lp + PL + 2) begin
        e_done = 1; e_busy = 1;
      end
      check($sformatf("%s c%0d", tag, j), obs_vec(),
            exp_vec(held_p, held_idx, e_ena, e_val, e_rst, e_busy, e_done, 1'b0));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic cfg_bad(input string tag, input logic [M-1:0] fs, input logic [M-1:0] fe,
                         input logic [M-1:0] st);
    f_start = fs; f_stop = fe; f_step = st; dwell = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " pulse"}, obs_vec(), exp_vec(held_p, held_idx, 0, 0, 0, 0, 0, 1));
    tick();
    check({tag, " after"}, obs_vec(), exp_vec(held_p, held_idx, 0, 0, 0, 0, 0, 0));
    tick();
    check({tag, " idle"}, obs_vec(), exp_vec(held_p, held_idx, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; val_out = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    held_p = '0; held_idx = '0;
    @(negedge clk);
    tick();
    tick();
    check("reset", obs_vec(), exp_vec('0, '0, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    check("reset release", obs_vec(), exp_vec('0, '0, 0, 0, 0, 0, 0, 0));

    run_sweep("basic", 27'd100, 27'd400, 27'd100, 16'd3, 0);
    check("basic final idx", {37'b0, step_idx},
`ifdef DDS_SWEEP_BIDIR_EN
          64'd6);
`else
          64'd3);
`endif
    run_sweep("top", TOP - 27'd9, TOP, 27'd8, 16'd1, 0);

    cfg_bad("step0", 27'd100, 27'd400, 27'd0);
    cfg_bad("start>stop", 27'd500, 27'd400, 27'd100);

    run_sweep("abort expiry", 27'd100, 27'd400, 27'd100, 16'd3, 7);
    run_sweep("abort mid", 27'd100, 27'd400, 27'd100, 16'd3, 5);
    run_sweep("abort clear", 27'd100, 27'd400, 27'd100, 16'd3, 1);
    run_sweep("dwell0", 27'd10, 27'd40, 27'd10, 16'd0, 0);
    run_sweep("single", 27'd77, 27'd77, 27'd5, 16'd2, 0);

    // Reset in the middle of a running sweep.
    f_start = 27'd100; f_stop = 27'd400; f_step = 27'd100; dwell = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("midrun reset", obs_vec(), exp_vec('0, '0, 0, 0, 1, 0, 0, 0));
    held_p = '0; held_idx = '0;
    rst_n = 1'b1;
    tick();
    check("midrun release", obs_vec(), exp_vec('0, '0, 0, 0, 0, 0, 0, 0));
    run_sweep("after reset", 27'd100, 27'd400, 27'd100, 16'd3, 0);

    for (int n = 0; n < 10; n++) begin
      logic [M-1:0] fs, fe, st;
      logic [D-1:0] dw;
      fs = M'($urandom_range(0, 2000));
      st = M'($urandom_range(40, 400));
      fe = fs + M'($urandom_range(0, 2000));
      dw = D'($urandom_range(0, 4));
      run_sweep($sformatf("rnd%0d", n), fs, fe, st, dw,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0);
    end
    for (int n = 0; n < 4; n++) begin
      logic [M-1:0] fs, st;
      fs = TOP - M'($urandom_range(0, 1000));
      st = M'($urandom_range(40, 400));
      run_sweep($sformatf("rndtop%0d", n), fs, TOP, st, D'($urandom_range(1, 3)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
